// File: rtl/table_pkg.sv
// Shared constants, dimensions and state encoding for the info-table printer and loader.
package table_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_STAR  = 8'h2A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam int TABLE_ROWS = 5;
  localparam int TABLE_COLS = 5;
  localparam int TABLE_BITS = 50;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR_TENS,
    S_HDR_ONES,
    S_HDR_SEP,
    S_ROW,
    S_STAR1,
    S_COL,
    S_STAR2,
    S_VAL,
    S_SEP,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] ERR_CHAR    = 2'd0;
  localparam logic [1:0] ERR_COUNT   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/table_char_class.sv
// Combinational byte classifier for the table loader: decimal digit, '*', and entry separators.
module table_char_class
  import table_pkg::*;
(
  input  logic [7:0] ch_i,
  output logic       is_digit_o,
  output logic [3:0] digit_o,
  output logic       is_star_o,
  output logic       is_sep_o
);

  assign is_digit_o = (ch_i >= ASCII_ZERO) && (ch_i <= ASCII_ZERO + 8'd9);
  assign digit_o    = is_digit_o ? 4'(ch_i - ASCII_ZERO) : 4'd0;
  assign is_star_o  = (ch_i == ASCII_STAR);
  assign is_sep_o   = (ch_i == ASCII_SPACE) || (ch_i == ASCII_CR) || (ch_i == ASCII_LF);

endmodule

// File: rtl/uart_table_loader.sv
// Parses "NN r*c*v<sep>..." from the UART RX into the 5x5 info table, committing atomically.
// Optional inter-byte idle timeout enabled by defining TABLE_LOADER_TIMEOUT_EN.
module uart_table_loader
  import table_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
  parameter int unsigned MAX_ENTRIES = 25
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  uart_rx_valid,
  input  logic [7:0]            uart_rx_data,
  output logic [TABLE_BITS-1:0] info_table,
  output logic [7:0]            cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code
);

  state_t                state_q, state_d;
  logic [7:0]            count_q, count_d;
  logic [7:0]            ent_q, ent_d;
  logic [2:0]            row_q, row_d;
  logic [2:0]            col_q, col_d;
  logic [TABLE_BITS-1:0] shadow_q, shadow_d;
  logic [TABLE_BITS-1:0] table_q, table_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [1:0]            err_code_q, err_code_d;

  logic       is_digit, is_star, is_sep;
  logic [3:0] digit;
  logic [4:0] cell_idx;
  logic       fail, finish;
  logic [1:0] fail_code;

`ifdef TABLE_LOADER_TIMEOUT_EN
  localparam logic [26:0] TO_LAST = 27'(TIMEOUT_CYCLES - 1);
  logic [26:0] idle_q, idle_d;
`endif

  table_char_class u_class (
    .ch_i      (uart_rx_data),
    .is_digit_o(is_digit),
    .digit_o   (digit),
    .is_star_o (is_star),
    .is_sep_o  (is_sep)
  );

  assign cell_idx = ({2'b00, row_q} - 5'd1) * 5'(TABLE_COLS) + ({2'b00, col_q} - 5'd1);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    ent_d      = ent_q;
    row_d      = row_q;
    col_d      = col_q;
    shadow_d   = shadow_q;
    table_d    = table_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    err_code_d = err_code_q;
    fail       = 1'b0;
    finish     = 1'b0;
    fail_code  = ERR_CHAR;
`ifdef TABLE_LOADER_TIMEOUT_EN
    idle_d     = idle_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // A byte arriving together with start is dropped on purpose.
        if (start) begin
          state_d    = S_HDR_TENS;
          shadow_d   = '0;
          ent_d      = '0;
          count_d    = '0;
          busy_d     = 1'b1;
          err_code_d = ERR_CHAR;
        end
      end
      S_HDR_TENS: if (uart_rx_valid) begin
        if (is_digit) begin
          count_d = 8'(digit) * 8'd10;
          state_d = S_HDR_ONES;
        end else fail = 1'b1;
      end
      S_HDR_ONES: if (uart_rx_valid) begin
        if (is_digit) begin
          count_d = count_q + {4'b0000, digit};
          state_d = S_HDR_SEP;
        end else fail = 1'b1;
      end
      S_HDR_SEP: if (uart_rx_valid) begin
        if (uart_rx_data != ASCII_SPACE) fail = 1'b1;
        else if (count_q > 8'(MAX_ENTRIES)) begin
          fail      = 1'b1;
          fail_code = ERR_COUNT;
        end else if (count_q == 8'd0) finish = 1'b1;
        else state_d = S_ROW;
      end
      S_ROW: if (uart_rx_valid) begin
        if (is_digit && digit != 4'd0 && digit <= 4'(TABLE_ROWS)) begin
          row_d   = digit[2:0];
          state_d = S_STAR1;
        end else fail = 1'b1;
      end
      S_STAR1: if (uart_rx_valid) begin
        if (is_star) state_d = S_COL;
        else fail = 1'b1;
      end
      S_COL: if (uart_rx_valid) begin
        if (is_digit && digit != 4'd0 && digit <= 4'(TABLE_COLS)) begin
          col_d   = digit[2:0];
          state_d = S_STAR2;
        end else fail = 1'b1;
      end
      S_STAR2: if (uart_rx_valid) begin
        if (is_star) state_d = S_VAL;
        else fail = 1'b1;
      end
      S_VAL: if (uart_rx_valid) begin
        if (is_digit && digit <= 4'd3) begin
          shadow_d[{cell_idx, 1'b0} +: 2] = digit[1:0];
          state_d = S_SEP;
        end else fail = 1'b1;
      end
      S_SEP: if (uart_rx_valid) begin
        if (is_sep) begin
          ent_d = ent_q + 8'd1;
          if (ent_d == count_q) finish = 1'b1;
          else state_d = S_ROW;
        end else fail = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef TABLE_LOADER_TIMEOUT_EN
    // busy_q is low in idle, so the counter is already clear when start arrives.
    if (!busy_q || uart_rx_valid) idle_d = '0;
    else if (idle_q == TO_LAST) begin
      fail      = 1'b1;
      fail_code = ERR_TIMEOUT;
    end else idle_d = idle_q + 27'd1;
`endif

    if (fail) begin
      state_d    = S_ERR;
      error_d    = 1'b1;
      busy_d     = 1'b0;
      err_code_d = fail_code;
    end else if (finish) begin
      state_d = S_DONE;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      table_d = shadow_d;
      cnt_d   = count_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      ent_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      shadow_q   <= '0;
      table_q    <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_CHAR;
`ifdef TABLE_LOADER_TIMEOUT_EN
      idle_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ent_q      <= ent_d;
      row_q      <= row_d;
      col_q      <= col_d;
      shadow_q   <= shadow_d;
      table_q    <= table_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
`ifdef TABLE_LOADER_TIMEOUT_EN
      idle_q     <= idle_d;
`endif
    end
  end

  assign info_table = table_q;
  assign cnt        = cnt_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign err_code   = err_code_q;

endmodule
